// File: rtl/sasa_qk_feeder_pkg.sv
// Shared SASA feeder types: FSM state encoding and the out-of-range read mask.
package sasa_qk_feeder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SERVE = 2'd2,
    S_DONE  = 2'd3
  } sasa_state_e;

  localparam logic [31:0] SASA_OOB_MASK = 32'h8000_0000;

endpackage

// File: rtl/sasa_qk_feeder_res_buf.sv
// SASA result buffer: RES_DEPTH x 32 write port, combinational read,
// saturating fill count and sticky overflow flag.
module sasa_res_buf #(
  parameter int RES_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_clear,
  input  logic                         i_wr_en,
  input  logic [31:0]                  i_wr_data,
  input  logic [$clog2(RES_DEPTH)-1:0] i_rd_addr,
  output logic [31:0]                  o_rd_data,
  output logic [$clog2(RES_DEPTH):0]   o_count,
  output logic                         o_ovf
);

  localparam int AW = $clog2(RES_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RES_DEPTH);

  logic [31:0]   r_mem [RES_DEPTH];
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_full;

  assign w_full = (r_count == DEPTH_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clear) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_wr_en) begin
      if (w_full) r_ovf <= 1'b1;
      else        r_count <= r_count + 1'b1;
    end
  end

  // Storage has no reset; only accepted captures write it.
  always_ff @(posedge clk) begin
    if (i_wr_en && !i_clear && !w_full)
      r_mem[r_count[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];
  assign o_count   = r_count;
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/sasa_qk_feeder.sv
// SASA Q/K feeder: loads a SEQ_LEN x SEQ_LEN matrix, serves reads, captures results.
// Build option: SASA_FEEDER_OOB_MASK_EN masks out-of-range reads instead of wrapping.
module sasa_qk_feeder
  import sasa_qk_feeder_pkg::*;
#(
  parameter int SEQ_LEN   = 16,
  parameter int ADDR_W    = 4,
  parameter int RES_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         load_valid,
  input  logic [31:0]                  load_data,
  output logic                         load_ready,
  input  logic                         data_req,
  input  logic [ADDR_W-1:0]            data_addr_x,
  input  logic [ADDR_W-1:0]            data_addr_y,
  output logic [31:0]                  data,
  output logic                         data_valid,
  input  logic                         soft_fac,
  input  logic [31:0]                  Result,
  input  logic                         finish,
  input  logic [$clog2(RES_DEPTH)-1:0] res_rd_addr,
  output logic [31:0]                  res_rd_data,
  output logic [$clog2(RES_DEPTH):0]   res_count,
  output logic                         res_ovf,
  output logic                         done,
  output logic [1:0]                   state
);

  localparam int NW = SEQ_LEN * SEQ_LEN;
  localparam int LW = $clog2(NW);
  localparam logic [LW-1:0]   LAST_C = LW'(NW - 1);
  localparam logic [ADDR_W:0] SL_C   = (ADDR_W + 1)'(SEQ_LEN);

  sasa_state_e r_state, w_next;

  logic [31:0]   r_mem [NW];
  logic [LW-1:0] r_lcnt;
  logic [31:0]   r_data;
  logic          r_valid;

  logic          w_accept;
  logic          w_serve;
  logic          w_x_oob, w_y_oob;
  logic [ADDR_W:0] w_xi, w_yi;
  logic [LW-1:0] w_idx;
  logic [31:0]   w_rd;

  assign load_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_accept   = load_valid && load_ready && !clear;
  assign w_serve    = (r_state == S_SERVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (load_valid) w_next = S_LOAD;
        S_LOAD:  if (load_valid && r_lcnt == LAST_C) w_next = S_SERVE;
        S_SERVE: if (finish) w_next = S_DONE;
        S_DONE:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_lcnt <= '0;
    else if (clear)    r_lcnt <= '0;
    else if (w_accept) r_lcnt <= (r_lcnt == LAST_C) ? '0 : r_lcnt + 1'b1;
  end

  // Row-major storage: the load count is the flat address.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_lcnt] <= load_data;
  end

  assign w_x_oob = ({1'b0, data_addr_x} >= SL_C);
  assign w_y_oob = ({1'b0, data_addr_y} >= SL_C);
  assign w_xi = w_x_oob ? {1'b0, data_addr_x} - SL_C : {1'b0, data_addr_x};
  assign w_yi = w_y_oob ? {1'b0, data_addr_y} - SL_C : {1'b0, data_addr_y};
  assign w_idx = LW'(w_yi) * LW'(SEQ_LEN) + LW'(w_xi);

`ifdef SASA_FEEDER_OOB_MASK_EN
  assign w_rd = (w_x_oob || w_y_oob) ? SASA_OOB_MASK : r_mem[w_idx];
`else
  assign w_rd = r_mem[w_idx];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (clear) begin
      r_valid <= 1'b0;
    end else if (w_serve && data_req) begin
      r_valid <= 1'b1;
      r_data  <= w_rd;
    end else begin
      r_valid <= 1'b0;
    end
  end

  sasa_res_buf #(
    .RES_DEPTH (RES_DEPTH)
  ) u_res_buf (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (clear),
    .i_wr_en   (soft_fac && w_serve),
    .i_wr_data (Result),
    .i_rd_addr (res_rd_addr),
    .o_rd_data (res_rd_data),
    .o_count   (res_count),
    .o_ovf     (res_ovf)
  );

  assign data       = r_data;
  assign data_valid = r_valid;
  assign done       = (r_state == S_DONE);
  assign state      = r_state;

endmodule
